// File: rtl/mem_processing_pkg.sv
// Shared types and constants for mem_processing: FSM state encoding,
// default geometry and the address-width helper.
package mem_processing_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_A_DEPTH = 8;

  typedef enum logic [1:0] {
    READA   = 2'd0,
    COMPUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  // Address bits needed for a memory of the given depth (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_processing_mem_array.sv
// Register-file memory: asynchronous clear of every word, one synchronous
// write port and two combinational read ports.
module mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr0,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: whole array cleared on reset, single write port otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read ports.
  always_comb begin
    o_rdata0 = mem[i_raddr0];
    o_rdata1 = mem[i_raddr1];
  end

endmodule

// File: rtl/mem_processing.sv
// mem_processing: captures A_DEPTH bytes into memory A, folds each pair into
// one word of memory B (difference if x>y, else sum), then halts until Init.
// Optional feature: define MEMPROC_SAT_EN to saturate the addition path.
// A_DEPTH must be a power of two and at least 4.
module mem_processing
  import mem_processing_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned A_DEPTH = DEF_A_DEPTH,
  localparam int unsigned AW_A   = addr_width(A_DEPTH),
  localparam int unsigned AW_B   = addr_width(A_DEPTH / 2)
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Init,
  input  logic [DATA_W-1:0] DataInA,
  input  logic [AW_B-1:0]   AddrB,
  output logic [DATA_W-1:0] DataOutB,
  output logic              Done
);

  localparam logic [AW_A-1:0] A_LAST = AW_A'(A_DEPTH - 1);
  // Index value one past the last B word: the cycle spent leaving COMPUTE.
  localparam logic [AW_B:0]   B_END  = (AW_B + 1)'(A_DEPTH / 2);

  state_t            r_state, w_state_nxt;
  logic [AW_A-1:0]   r_addr_a, w_addr_a_nxt;
  logic [AW_B:0]     r_idx, w_idx_nxt;
  logic              w_we_a, w_we_b;
  logic [AW_A-1:0]   w_raddr_x, w_raddr_y;
  logic [AW_B-1:0]   w_waddr_b;
  logic [DATA_W-1:0] w_x, w_y, w_add, w_result;
  logic [DATA_W-1:0] w_b_rd_spare;

  assign w_waddr_b = r_idx[AW_B-1:0];
  assign w_raddr_x = {w_waddr_b, 1'b0};
  assign w_raddr_y = {w_waddr_b, 1'b1};

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (A_DEPTH),
    .ADDR_W (AW_A)
  ) MemoryA (
    .i_clk    (clock),
    .i_rst_n  (Reset),
    .i_we     (w_we_a),
    .i_waddr  (r_addr_a),
    .i_wdata  (DataInA),
    .i_raddr0 (w_raddr_x),
    .i_raddr1 (w_raddr_y),
    .o_rdata0 (w_x),
    .o_rdata1 (w_y)
  );

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (A_DEPTH / 2),
    .ADDR_W (AW_B)
  ) MemoryB (
    .i_clk    (clock),
    .i_rst_n  (Reset),
    .i_we     (w_we_b),
    .i_waddr  (w_waddr_b),
    .i_wdata  (w_result),
    .i_raddr0 (AddrB),
    .i_raddr1 (AddrB),
    .o_rdata0 (DataOutB),
    .o_rdata1 (w_b_rd_spare)
  );

`ifdef MEMPROC_SAT_EN
  logic [DATA_W:0] w_sum_full;
  // Saturating add: clamp to all-ones on carry out.
  always_comb begin
    w_sum_full = {1'b0, w_x} + {1'b0, w_y};
    w_add      = w_sum_full[DATA_W] ? '1 : w_sum_full[DATA_W-1:0];
  end
`else
  // Wrapping add, modulo 2^DATA_W.
  always_comb begin
    w_add = w_x + w_y;
  end
`endif

  // Pair combine: unsigned difference when x>y, otherwise the sum.
  always_comb begin
    w_result = (w_x > w_y) ? (w_x - w_y) : w_add;
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= READA;
      r_addr_a <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr_a <= w_addr_a_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  // Next-state, counter and write-enable decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_a_nxt = r_addr_a;
    w_idx_nxt    = r_idx;
    w_we_a       = 1'b0;
    w_we_b       = 1'b0;
    unique case (r_state)
      READA: begin
        if (Init) begin
          w_addr_a_nxt = '0;
        end else begin
          w_we_a       = 1'b1;
          w_addr_a_nxt = r_addr_a + 1'b1;
          if (r_addr_a == A_LAST) begin
            w_state_nxt = COMPUTE;
            w_idx_nxt   = '0;
          end
        end
      end
      COMPUTE: begin
        if (Init) begin
          w_state_nxt  = READA;
          w_addr_a_nxt = '0;
        end else if (r_idx == B_END) begin
          w_state_nxt = HALT;
        end else begin
          w_we_b    = 1'b1;
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      HALT: begin
        if (Init) begin
          w_state_nxt  = READA;
          w_addr_a_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = READA;
        w_addr_a_nxt = '0;
      end
    endcase
  end

  assign Done = (r_state == HALT);

endmodule

// File: tb/tb_mem_processing.sv
// Directed bench for mem_processing with hand-computed expected B contents.
module tb_mem_processing;

  logic       clock;
  logic       Reset;
  logic       Init;
  logic [7:0] DataInA;
  logic [1:0] AddrB;
  logic [7:0] DataOutB;
  logic       Done;

  int n_checks;
  int n_errors;

  mem_processing dut (
    .clock    (clock),
    .Reset    (Reset),
    .Init     (Init),
    .DataInA  (DataInA),
    .AddrB    (AddrB),
    .DataOutB (DataOutB),
    .Done     (Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then move 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Capture eight bytes with Init low; leaves the DUT entering COMPUTE.
  task automatic feed(input logic [7:0] b [8]);
    Init = 1'b0;
    for (int k = 0; k < 8; k++) begin
      DataInA = b[k];
      step();
    end
  endtask

  // Four B writes, then Done must rise on the fifth compute-phase edge (edge 13).
  task automatic finish_compute(input string tag);
    for (int k = 0; k < 4; k++) step();
    check({tag, "_done_edge12"}, {31'd0, Done}, 32'd0);
    step();
    check({tag, "_done_edge13"}, {31'd0, Done}, 32'd1);
  endtask

  task automatic read_b(input string tag, input logic [7:0] e [4]);
    for (int k = 0; k < 4; k++) begin
      AddrB = 2'(k);
      #1;
      check($sformatf("%s_b%0d", tag, k), {24'd0, DataOutB}, {24'd0, e[k]});
    end
  endtask

  logic [7:0] nominal [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd6, 8'd5, 8'd4};
  logic [7:0] nom_b   [4] = '{8'd1, 8'd5, 8'd1, 8'd1};
  logic [7:0] bnd     [8] = '{8'd200, 8'd100, 8'd100, 8'd100, 8'd0, 8'd255, 8'd255, 8'd0};
  logic [7:0] bnd_b   [4] = '{8'd100, 8'd200, 8'd255, 8'd255};
  logic [7:0] ovf     [8] = '{8'd200, 8'd200, 8'd1, 8'd2, 8'd3, 8'd3, 8'd9, 8'd4};
  logic [7:0] ovf_b   [4];
  logic [7:0] abt     [8] = '{8'd30, 8'd10, 8'd40, 8'd50, 8'd5, 8'd6, 8'd7, 8'd8};
  logic [7:0] abt_b   [4] = '{8'd20, 8'd90, 8'd1, 8'd1};
  logic [7:0] zero_b  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef MEMPROC_SAT_EN
    ovf_b = '{8'd255, 8'd3, 8'd6, 8'd5};
`else
    ovf_b = '{8'd144, 8'd3, 8'd6, 8'd5};
`endif
    Reset   = 1'b0;
    Init    = 1'b1;
    DataInA = 8'd0;
    AddrB   = 2'd0;
    #1;
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_dout", {24'd0, DataOutB}, 32'd0);
    step();
    Reset = 1'b1;
    step();
    step();
    check("init_hold_done", {31'd0, Done}, 32'd0);

    // Nominal pass
    feed(nominal);
    finish_compute("nominal");
    read_b("nominal", nom_b);

    // Re-arm: Init held high keeps the block idle in READA with B intact
    Init    = 1'b1;
    DataInA = 8'hAA;
    step();
    check("rearm_done", {31'd0, Done}, 32'd0);
    for (int k = 0; k < 10; k++) step();
    check("rearm_hold_done", {31'd0, Done}, 32'd0);
    read_b("rearm", nom_b);

    // Boundary values
    feed(bnd);
    finish_compute("bound");
    read_b("bound", bnd_b);
    Init = 1'b1;
    step();
    feed(ovf);
    finish_compute("ovf");
    read_b("ovf", ovf_b);

    // Restart mid-capture
    Init = 1'b1;
    step();
    Init = 1'b0;
    for (int k = 0; k < 3; k++) begin
      DataInA = 8'd9;
      step();
    end
    Init = 1'b1;
    step();
    feed(nominal);
    finish_compute("restart");
    read_b("restart", nom_b);

    // Asynchronous reset in COMPUTE, between edges
    Init = 1'b1;
    step();
    feed(ovf);
    step();
    step();
    #2;
    Reset = 1'b0;
    #1;
    check("areset_done", {31'd0, Done}, 32'd0);
    read_b("areset", zero_b);
    Init = 1'b1;
    step();
    Reset = 1'b1;
    step();
    feed(nominal);
    finish_compute("post_reset");
    read_b("post_reset", nom_b);

    // Abort after two B writes
    Init = 1'b1;
    step();
    feed(abt);
    step();
    step();
    Init = 1'b1;
    step();
    check("abort_done", {31'd0, Done}, 32'd0);
    for (int k = 0; k < 6; k++) step();
    check("abort_hold_done", {31'd0, Done}, 32'd0);
    read_b("abort", abt_b);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
